// File: rtl/bus_mux_pkg.sv
// bus_mux_pkg: shared definitions for the bus_mux_arb source selector.
//   mode_e        : mode port encodings (direct select / round-robin)
//   *_MIN/*_MAX   : legal ranges for WIDTH and NCH
//   onehot_to_idx : binary index of a one-hot vector up to NCH_MAX bits
package bus_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int NCH_MIN   = 2;
  localparam int NCH_MAX   = 16;
  localparam int IDX_W     = $clog2(NCH_MAX);

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NCH_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NCH_MAX; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Compiled only when BUS_MUX_ARB_RR_EN is defined; otherwise this file
// contributes nothing and the parent runs in direct-select mode only.
//   req   in  NCH   per-channel request
//   ptr   in  SELW  last granted channel; search starts at ptr+1 and wraps
//   grant out NCH   one-hot grant (all zero when no request)
//   idx   out SELW  binary index of grant (0 when no request)
//   any   out 1     some channel granted
`ifdef BUS_MUX_ARB_RR_EN
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter  int NCH  = 3,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  always_comb begin
    int unsigned c;
    grant = '0;
    c     = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      c = (32'(ptr) + k) % NCH;
      if (grant == '0 && req[c[SELW-1:0]]) grant[c[SELW-1:0]] = 1'b1;
    end
    idx = SELW'(onehot_to_idx(NCH_MAX'(grant)));
    any = |grant;
  end

endmodule
`endif

// File: rtl/bus_mux_arb.sv
// bus_mux_arb: registered N-channel bus selector with valid/ready output.
// Selects a source by direct code (madd) or, when BUS_MUX_ARB_RR_EN is
// defined, by round-robin arbitration (mode=1). Without the macro the mode
// port is ignored and the block always runs in direct mode.
//   clk, rst_n  clock / async active-low reset
//   mode        0 direct, 1 round-robin
//   madd        direct-mode channel select
//   in_data     flattened sources, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid;  in_ready  per-channel ready (one-hot or 0)
//   y, y_valid  registered output word and valid;  y_ready downstream accept
//   y_src       channel that produced y
//   sel_err     sticky direct-mode out-of-range select;  err_clr clears it
module bus_mux_arb
  import bus_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 3,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      madd,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SELW-1:0]      y_src,
  output logic                 sel_err,
  input  logic                 err_clr
);

  logic             slot_free;
  logic             madd_ok;
  logic             bad_sel;
  logic             gany;
  logic             xfer;
  logic [NCH-1:0]   dgrant;
  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] gdata;

  assign slot_free = !y_valid || y_ready;
  assign madd_ok   = 32'(madd) < 32'(NCH);

  always_comb begin
    dgrant = '0;
    if (madd_ok && in_valid[madd]) dgrant[madd] = 1'b1;
  end

`ifdef BUS_MUX_ARB_RR_EN
  logic            mode_rr;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic [NCH-1:0]  rr_grant;
  logic            rr_any;

  assign mode_rr = (mode_e'(mode) == MODE_RR);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign grant   = mode_rr ? rr_grant : dgrant;
  assign gidx    = mode_rr ? rr_idx : madd;
  assign gany    = mode_rr ? rr_any : |dgrant;
  assign bad_sel = !mode_rr && !madd_ok;

  // ptr survives mode switches; only RR transfers move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= SELW'(NCH - 1);
    else if (xfer && mode_rr) ptr <= rr_idx;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant       = dgrant;
  assign gidx        = madd;
  assign gany        = |dgrant;
  assign bad_sel     = !madd_ok;
`endif

  assign xfer = gany && slot_free;
  // Gated by rst_n so no handshake can complete while reset is asserted.
  assign in_ready = (rst_n && slot_free) ? grant : '0;

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gidx == SELW'(i)) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_src   <= '0;
      sel_err <= 1'b0;
    end else begin
      if (xfer) begin
        y       <= gdata;
        y_src   <= gidx;
        y_valid <= 1'b1;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
      // Set has priority over clear.
      if (bad_sel)      sel_err <= 1'b1;
      else if (err_clr) sel_err <= 1'b0;
    end
  end

endmodule
